load_store_unit: RTL and testbench

Memory-side partner of the datapath. It takes a load/store request from the controller's memory state, together with the effective address (datapath_out) and the store data (str_data). It drives a synchronous-read data RAM, then returns load results to the register file through the datapath's LDR write port (w_en_ldr / w_addr_ldr / w_data_ldr). The block covers the controller's memory and memory_wait states and handles byte/word formatting, alignment faults and fixed-latency RAM reads.

---
 rtl/lsu_pkg.sv | 41 ++++
 rtl/load_store_unit_fmt.sv | 33 +++
 rtl/load_store_unit.sv | 140 ++++++++++++++
 tb/tb_load_store_unit.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// Byte lanes are little-endian: lane i covers bits [8*i+7:8*i].
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        WRITEBACK
    } lsu_state_t;

    localparam logic [3:0] BYTEEN_WORD = 4'b1111;

    function automatic logic [3:0] byte_lane_en(input logic [1:0] lane);
        logic [3:0] en;
        unique case (lane)
            2'd0: en = 4'b0001;
            2'd1: en = 4'b0010;
            2'd2: en = 4'b0100;
            2'd3: en = 4'b1000;
            default: en = 4'b0000;
        endcase
        return en;
    endfunction

    function automatic logic [7:0] byte_extract(
        input logic [31:0] word,
        input logic [1:0]  lane
    );
        logic [7:0] b;
        unique case (lane)
            2'd0: b = word[7:0];
            2'd1: b = word[15:8];
            2'd2: b = word[23:16];
            2'd3: b = word[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/load_store_unit_fmt.sv
// Combinational store/load data formatter for the load/store unit.
// Store side works on live request inputs, load side on latched lane info.
module lsu_fmt
    import lsu_pkg::*;
(
    input  logic        st_byte,
    input  logic [1:0]  st_lane,
    input  logic [31:0] str_data,
    input  logic        ld_byte,
    input  logic [1:0]  ld_lane,
    input  logic [31:0] ram_rdata,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_byteen,
    output logic [31:0] ld_data
);

    always_comb begin
        st_wdata  = str_data;
        st_byteen = BYTEEN_WORD;
        if (st_byte) begin
            st_wdata  = {4{str_data[7:0]}};
            st_byteen = byte_lane_en(st_lane);
        end
    end

    always_comb begin
        ld_data = ram_rdata;
        if (ld_byte) begin
            ld_data = {24'h0, byte_extract(ram_rdata, ld_lane)};
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: drives a synchronous-read data RAM and returns load
// results to the register file through the LDR write port.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W       = 11,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_req,
    input  logic              mem_is_load,
    input  logic              mem_byte,
    input  logic [31:0]       addr,
    input  logic [31:0]       str_data,
    input  logic [3:0]        ldr_dest,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic              ram_wren,
    output logic [3:0]        ram_byteen,
    input  logic [31:0]       ram_rdata,
    output logic              w_en_ldr,
    output logic [3:0]        w_addr_ldr,
    output logic [31:0]       w_data_ldr,
    output logic              lsu_busy,
    output logic              lsu_done,
    output logic              lsu_fault
);

    localparam logic [2:0] LAST_WAIT = 3'(READ_LATENCY - 1);

    lsu_state_t  state;
    logic [2:0]  cnt;
    logic        go_wait;
    logic        byte_q;
    logic [1:0]  lane_q;
    logic [3:0]  dest_q;

    logic        wren_q;
    logic        w_en_q;
    logic        done_q;
    logic        fault_q;

    logic [31:0] st_wdata;
    logic [3:0]  st_byteen;
    logic [31:0] ld_data;
    logic        misaligned;

    logic        unused_addr_hi;
    assign unused_addr_hi = ^addr[31:ADDR_W+2];

    assign misaligned = !mem_byte && (addr[1:0] != 2'b00);

    lsu_fmt u_fmt (
        .st_byte   (mem_byte),
        .st_lane   (addr[1:0]),
        .str_data  (str_data),
        .ld_byte   (byte_q),
        .ld_lane   (lane_q),
        .ram_rdata (ram_rdata),
        .st_wdata  (st_wdata),
        .st_byteen (st_byteen),
        .ld_data   (ld_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 3'd0;
            go_wait    <= 1'b0;
            byte_q     <= 1'b0;
            lane_q     <= 2'd0;
            dest_q     <= 4'd0;
            ram_addr   <= '0;
            ram_wdata  <= 32'h0;
            ram_byteen <= 4'h0;
            w_addr_ldr <= 4'd0;
            w_data_ldr <= 32'h0;
            wren_q     <= 1'b0;
            w_en_q     <= 1'b0;
            done_q     <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-armed below
            wren_q  <= 1'b0;
            w_en_q  <= 1'b0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (mem_req) begin
                        byte_q     <= mem_byte;
                        lane_q     <= addr[1:0];
                        dest_q     <= ldr_dest;
                        go_wait    <= mem_is_load && !misaligned;
                        ram_addr   <= addr[ADDR_W+1:2];
                        ram_wdata  <= st_wdata;
                        ram_byteen <= st_byteen;
                        if (misaligned) begin
                            fault_q <= 1'b1;
                            done_q  <= 1'b1;
                        end else if (!mem_is_load) begin
                            wren_q <= 1'b1;
                            done_q <= 1'b1;
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= 3'd0;
                    state <= go_wait ? WAIT : IDLE;
                end
                WAIT: begin
                    if (cnt == LAST_WAIT) begin
                        w_data_ldr <= ld_data;
                        w_addr_ldr <= dest_q;
                        w_en_q     <= 1'b1;
                        done_q     <= 1'b1;
                        state      <= WRITEBACK;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                WRITEBACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign ram_wren  = wren_q & ~rst;
    assign w_en_ldr  = w_en_q & ~rst;
    assign lsu_done  = done_q & ~rst;
    assign lsu_fault = fault_q & ~rst;
    assign lsu_busy  = (state != IDLE);

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a behavioural RAM and
// a transaction-level memory model.
module tb_load_store_unit;

    localparam int RL = 3;
    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_req;
    logic          mem_is_load;
    logic          mem_byte;
    logic [31:0]   addr;
    logic [31:0]   str_data;
    logic [3:0]    ldr_dest;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic          ram_wren;
    logic [3:0]    ram_byteen;
    logic [31:0]   ram_rdata;
    logic          w_en_ldr;
    logic [3:0]    w_addr_ldr;
    logic [31:0]   w_data_ldr;
    logic          lsu_busy;
    logic          lsu_done;
    logic          lsu_fault;

    int vecs = 0;
    int errs = 0;

    logic [31:0] ref_mem [16];

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(AW), .READ_LATENCY(RL)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_req    (mem_req),
        .mem_is_load(mem_is_load),
        .mem_byte   (mem_byte),
        .addr       (addr),
        .str_data   (str_data),
        .ldr_dest   (ldr_dest),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_wren   (ram_wren),
        .ram_byteen (ram_byteen),
        .ram_rdata  (ram_rdata),
        .w_en_ldr   (w_en_ldr),
        .w_addr_ldr (w_addr_ldr),
        .w_data_ldr (w_data_ldr),
        .lsu_busy   (lsu_busy),
        .lsu_done   (lsu_done),
        .lsu_fault  (lsu_fault)
    );

    // Synchronous RAM with RL-stage read pipeline
    logic [31:0] mem [0:2047];
    logic [31:0] rpipe [RL];

    always @(posedge clk) begin
        if (ram_wren) begin
            for (int i = 0; i < 4; i++) begin
                if (ram_byteen[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
            end
        end
        rpipe[0] <= mem[ram_addr];
        for (int i = 1; i < RL; i++) rpipe[i] <= rpipe[i-1];
    end

    assign ram_rdata = rpipe[RL-1];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request through the DUT, checked against the reference model
    task automatic run_op(input bit ld, input bit by, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] dest);
        bit          fault;
        int          exp_lat;
        int          n;
        bit          got;
        bit          stray_wren;
        bit          stray_wen;
        bit          busy_low;
        int          idx;
        int          lane;
        logic [31:0] exp_ld;
        logic [31:0] exp_wd;
        logic [3:0]  exp_be;
        logic [31:0] s_wd, s_wld;
        logic [3:0]  s_be, s_wa;
        logic [AW-1:0] s_ra;
        logic        s_wren, s_wen, s_fault;

        fault   = !by && (a[1:0] != 2'b00);
        exp_lat = (fault || !ld) ? 1 : RL + 2;
        idx     = int'(a[5:2]);
        lane    = int'(a[1:0]);
        exp_ld  = by ? ((ref_mem[idx] >> (8 * lane)) & 32'hFF) : ref_mem[idx];
        exp_wd  = by ? (d & 32'hFF) * 32'h0101_0101 : d;
        exp_be  = by ? 4'(1 << lane) : 4'hF;

        mem_is_load = ld;
        mem_byte    = by;
        addr        = a;
        str_data    = d;
        ldr_dest    = dest;
        mem_req     = 1'b1;
        n = 0; got = 0; stray_wren = 0; stray_wen = 0; busy_low = 0;
        {s_wd, s_wld, s_be, s_wa, s_ra, s_wren, s_wen, s_fault} = '0;
        while (!got && n < 20) begin
            tick();
            n++;
            if (!lsu_busy) busy_low = 1;
            if (lsu_done) begin
                got = 1;
                s_wd = ram_wdata; s_be = ram_byteen; s_ra = ram_addr;
                s_wren = ram_wren; s_wen = w_en_ldr; s_fault = lsu_fault;
                s_wa = w_addr_ldr; s_wld = w_data_ldr;
            end else begin
                if (ram_wren) stray_wren = 1;
                if (w_en_ldr) stray_wen = 1;
            end
        end
        mem_req = 1'b0;

        vecs++;
        if (!got || n != exp_lat) begin
            errs++;
            $display("FAIL latency a=%h ld=%0d by=%0d: got %0d cycles (done=%0d) need %0d",
                     a, ld, by, n, got, exp_lat);
        end
        vecs++;
        if (busy_low || stray_wren || stray_wen) begin
            errs++;
            $display("FAIL pulses a=%h: busy_low=%0d stray_wren=%0d stray_wen=%0d need 0 0 0",
                     a, busy_low, stray_wren, stray_wen);
        end
        vecs++;
        if (s_fault !== fault) begin
            errs++;
            $display("FAIL fault a=%h: got %0d need %0d", a, s_fault, fault);
        end
        vecs++;
        if (s_wren !== (!ld && !fault) || s_wen !== (ld && !fault)) begin
            errs++;
            $display("FAIL strobes a=%h: wren=%0d w_en=%0d need %0d %0d",
                     a, s_wren, s_wen, !ld && !fault, ld && !fault);
        end
        if (!fault && !ld) begin
            vecs++;
            if (s_wd !== exp_wd || s_be !== exp_be || s_ra !== AW'(a >> 2)) begin
                errs++;
                $display("FAIL store a=%h: wdata=%h be=%b ra=%h need %h %b %h",
                         a, s_wd, s_be, s_ra, exp_wd, exp_be, AW'(a >> 2));
            end
            for (int i = 0; i < 4; i++) begin
                if (exp_be[i]) ref_mem[idx][8*i +: 8] = exp_wd[8*i +: 8];
            end
        end
        if (!fault && ld) begin
            vecs++;
            if (s_wld !== exp_ld || s_wa !== dest) begin
                errs++;
                $display("FAIL load a=%h: data=%h dest=%0d need %h %0d",
                         a, s_wld, s_wa, exp_ld, dest);
            end
        end
        tick();
        vecs++;
        if (lsu_busy !== 1'b0 || lsu_done !== 1'b0 || ram_wren !== 1'b0 || w_en_ldr !== 1'b0) begin
            errs++;
            $display("FAIL after_done a=%h: busy=%0d done=%0d wren=%0d w_en=%0d need 0",
                     a, lsu_busy, lsu_done, ram_wren, w_en_ldr);
        end
    endtask

    task automatic check_zero(input string tag);
        vecs++;
        if ({ram_addr, ram_wdata, ram_byteen, ram_wren, w_en_ldr, w_addr_ldr,
             w_data_ldr, lsu_busy, lsu_done, lsu_fault} !== '0) begin
            errs++;
            $display("FAIL %s: ra=%h wd=%h be=%b wren=%0d wen=%0d wa=%0d wld=%h busy=%0d done=%0d flt=%0d need all 0",
                     tag, ram_addr, ram_wdata, ram_byteen, ram_wren, w_en_ldr,
                     w_addr_ldr, w_data_ldr, lsu_busy, lsu_done, lsu_fault);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_req = 1'b1; mem_is_load = 1'b0; mem_byte = 1'b0;
        addr = 32'h10; str_data = 32'hFFFF_FFFF; ldr_dest = 4'd7;
        tick(); tick();
        check_zero("reset_state");
        mem_req = 1'b0;
        rst = 1'b0;
        tick();
        check_zero("idle_after_reset");
    endtask

    task automatic test_directed();
        run_op(1'b0, 1'b0, 32'h10, 32'h1234_5678, 4'd0);
        run_op(1'b1, 1'b0, 32'h10, 32'h0, 4'd3);
        run_op(1'b0, 1'b0, 32'h10, 32'hDEAD_BEEF, 4'd0);
        run_op(1'b1, 1'b0, 32'h10, 32'h0, 4'd15);
        run_op(1'b0, 1'b1, 32'h13, 32'h0000_00AB, 4'd0);
        run_op(1'b1, 1'b1, 32'h13, 32'h0, 4'd9);
        run_op(1'b0, 1'b1, 32'h10, 32'h5555_5511, 4'd0);
        run_op(1'b1, 1'b1, 32'h10, 32'h0, 4'd1);
        run_op(1'b1, 1'b0, 32'h10, 32'h0, 4'd2);
    endtask

    task automatic test_fault();
        run_op(1'b1, 1'b0, 32'h12, 32'h0, 4'd4);
        run_op(1'b0, 1'b0, 32'h11, 32'hCAFE_F00D, 4'd0);
        run_op(1'b0, 1'b0, 32'h17, 32'h0BAD_0BAD, 4'd0);
        run_op(1'b1, 1'b0, 32'h10, 32'h0, 4'd6);
        run_op(1'b1, 1'b0, 32'h14, 32'h0, 4'd6);
    endtask

    task automatic test_reset_mid();
        bit bad = 0;
        mem_is_load = 1'b1; mem_byte = 1'b0; addr = 32'h10; ldr_dest = 4'd5;
        mem_req = 1'b1;
        tick();
        mem_req = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        if (w_en_ldr || lsu_done) bad = 1;
        tick();
        check_zero("reset_mid_load");
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (w_en_ldr || lsu_done || lsu_busy) bad = 1;
        end
        vecs++;
        if (bad) begin
            errs++;
            $display("FAIL reset_abort: activity after aborted load got 1 need 0");
        end
        run_op(1'b1, 1'b0, 32'h10, 32'h0, 4'd5);
    endtask

    task automatic test_busy_ignore();
        int n = 0;
        int dones = 0;
        bit wr = 0;
        mem_is_load = 1'b1; mem_byte = 1'b0; addr = 32'h14; ldr_dest = 4'd8;
        mem_req = 1'b1;
        tick();
        mem_req = 1'b0;
        tick();
        mem_is_load = 1'b0; addr = 32'h18; str_data = 32'h7777_7777;
        mem_req = 1'b1;
        tick();
        mem_req = 1'b0;
        n = 3;
        while (dones == 0 && n < 20) begin
            if (lsu_done) dones++;
            if (ram_wren) wr = 1;
            if (dones == 0) begin
                tick();
                n++;
            end
        end
        vecs++;
        if (n != RL + 2 || w_data_ldr !== ref_mem[5] || w_addr_ldr !== 4'd8) begin
            errs++;
            $display("FAIL busy_load: lat=%0d data=%h dest=%0d need %0d %h 8",
                     n, w_data_ldr, w_addr_ldr, RL + 2, ref_mem[5]);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (lsu_done || lsu_busy) dones++;
            if (ram_wren) wr = 1;
        end
        vecs++;
        if (dones != 1 || wr) begin
            errs++;
            $display("FAIL busy_ignore: done_pulses=%0d wren=%0d need 1 0", dones, wr);
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        mem_is_load = 1'b1; mem_byte = 1'b0; addr = 32'h1C; ldr_dest = 4'd11;
        mem_req = 1'b1;
        do begin
            tick();
            n++;
        end while (!lsu_done && n < 20);
        vecs++;
        if (n != RL + 2 || w_data_ldr !== ref_mem[7]) begin
            errs++;
            $display("FAIL b2b_load: lat=%0d data=%h need %0d %h",
                     n, w_data_ldr, RL + 2, ref_mem[7]);
        end
        mem_is_load = 1'b0; mem_byte = 1'b1; addr = 32'h1D; str_data = 32'h0000_00C3;
        tick();
        vecs++;
        if (lsu_busy !== 1'b0 || lsu_done !== 1'b0 || ram_wren !== 1'b0) begin
            errs++;
            $display("FAIL b2b_gap: busy=%0d done=%0d wren=%0d need 0 0 0",
                     lsu_busy, lsu_done, ram_wren);
        end
        tick();
        mem_req = 1'b0;
        vecs++;
        if (ram_wren !== 1'b1 || lsu_done !== 1'b1 || ram_byteen !== 4'b0010 ||
            ram_wdata !== 32'hC3C3_C3C3) begin
            errs++;
            $display("FAIL b2b_store: wren=%0d done=%0d be=%b wd=%h need 1 1 0010 c3c3c3c3",
                     ram_wren, lsu_done, ram_byteen, ram_wdata);
        end
        ref_mem[7][15:8] = 8'hC3;
        tick();
        run_op(1'b1, 1'b0, 32'h1C, 32'h0, 4'd12);
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int i = 0; i < 16; i++) begin
            run_op(1'b0, 1'b0, 32'(i * 4), $urandom, 4'd0);
        end
        for (int i = 0; i < 150; i++) begin
            a = {$urandom_range(0, 524287), 13'h0} | 32'($urandom_range(0, 63));
            run_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a,
                   $urandom, 4'($urandom_range(0, 15)));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_fault();
        test_reset_mid();
        test_busy_ignore();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
